// File: rtl/arroz_mem_arbiter_pkg.sv
// Shared constants for the arrozYleche memory-port arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode selectors
//   id_width()         : bits needed to encode a master index (minimum 1)
package arroz_mem_arbiter_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arroz_mem_arbiter_rr_arbiter.sv
// Combinational requestor arbiter.
//   req    : per-master request vector
//   ptr    : round-robin search start (ignored in fixed-priority mode)
//   gnt    : one-hot grant, zero when no request
//   gnt_id : encoded index of the granted master
module rr_arbiter
  import arroz_mem_arbiter_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned MODE = ARB_RR,
  parameter int unsigned IDW  = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    if (MODE == ARB_FIXED) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!found && req[i]) begin
          gnt[i] = 1'b1;
          gnt_id = IDW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      // First pass searches ptr..N-1, second pass wraps around to 0..ptr-1.
      for (int i = 0; i < int'(N); i++) begin
        if (!found && req[i] && (IDW'(i) >= ptr)) begin
          gnt[i] = 1'b1;
          gnt_id = IDW'(i);
          found  = 1'b1;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (!found && req[i] && (IDW'(i) < ptr)) begin
          gnt[i] = 1'b1;
          gnt_id = IDW'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arroz_mem_arbiter.sv
// Memory-port arbiter: shares one synchronous-read memory port among
// NUM_MASTERS requestors, one access per cycle, reads returned to their owner
// after RD_LATENCY+1 cycles.
//   clk, reset          : clock, async active-low reset
//   m_req/m_we/m_adr/m_wdata : per-master request, write flag, packed address/data
//   m_gnt               : one-hot grant (combinational)
//   m_rvalid/m_rdata    : read-return pulse to owner and shared read data
//   memdata             : data from memory
//   memwrite/adr/memOut : registered memory-side controls
module arroz_mem_arbiter
  import arroz_mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ARB_MODE    = ARB_RR
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*WIDTH-1:0]      m_wdata,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [WIDTH-1:0]                  m_rdata,
  input  logic [WIDTH-1:0]                  memdata,
  output logic                              memwrite,
  output logic [ADDR_WIDTH-1:0]             adr,
  output logic [WIDTH-1:0]                  memOut
);

  localparam int unsigned IDW  = id_width(NUM_MASTERS);
  localparam int unsigned LAST = RD_LATENCY - 1;

  logic [IDW-1:0]         ptr_q;
  logic [IDW-1:0]         ptr_d;
  logic [IDW-1:0]         gnt_id;
  logic                   accept;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_adr;
  logic [WIDTH-1:0]       sel_wdata;
  logic [RD_LATENCY-1:0]  rd_vld_q;
  logic [IDW-1:0]         rd_id_q [RD_LATENCY];
  logic [NUM_MASTERS-1:0] rvalid_d;

  rr_arbiter #(
    .N    (NUM_MASTERS),
    .MODE (ARB_MODE),
    .IDW  (IDW)
  ) u_arb (
    .req    (m_req),
    .ptr    (ptr_q),
    .gnt    (m_gnt),
    .gnt_id (gnt_id)
  );

  // Payload of the granted master; grant is only ever set where a request is.
  always_comb begin
    accept    = |m_gnt;
    sel_we    = 1'b0;
    sel_adr   = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (m_gnt[i]) begin
        sel_we    = m_we[i];
        sel_adr   = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = m_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves past the accepted master; fixed priority leaves it at zero.
  always_comb begin
    ptr_d = ptr_q;
    if ((ARB_MODE == ARB_RR) && accept) begin
      ptr_d = (gnt_id == IDW'(NUM_MASTERS - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Decode the owner of the read leaving the return pipe.
  always_comb begin
    rvalid_d = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (rd_id_q[LAST] == IDW'(i)) rvalid_d[i] = rd_vld_q[LAST];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      memwrite <= 1'b0;
      adr      <= '0;
      memOut   <= '0;
      rd_vld_q <= '0;
      for (int k = 0; k < int'(RD_LATENCY); k++) rd_id_q[k] <= '0;
      m_rvalid <= '0;
      m_rdata  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      memwrite <= accept & sel_we;
      if (accept) begin
        adr    <= sel_adr;
        memOut <= sel_wdata;
      end
      rd_vld_q[0] <= accept & ~sel_we;
      rd_id_q[0]  <= gnt_id;
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        rd_vld_q[k] <= rd_vld_q[k-1];
        rd_id_q[k]  <= rd_id_q[k-1];
      end
      m_rvalid <= rvalid_d;
      if (rd_vld_q[LAST]) m_rdata <= memdata;
    end
  end

endmodule

// File: tb/tb_arroz_mem_arbiter.sv
// Bench for arroz_mem_arbiter: two instances (round-robin with read latency 2,
// fixed priority with read latency 1) checked every cycle against a
// transaction-level model of grants, memory-side outputs and read returns.
`timescale 1ns/1ps
module tb_arroz_mem_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int AW = 16;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0]    m_req    [NI];
  logic [N-1:0]    m_we     [NI];
  logic [N*AW-1:0] m_adr    [NI];
  logic [N*W-1:0]  m_wdata  [NI];
  logic [N-1:0]    m_gnt    [NI];
  logic [N-1:0]    m_rvalid [NI];
  logic [W-1:0]    m_rdata  [NI];
  logic [W-1:0]    memdata  [NI];
  logic            memwrite [NI];
  logic [AW-1:0]   adr      [NI];
  logic [W-1:0]    mem_out  [NI];

  always #5 clk = ~clk;

  arroz_mem_arbiter #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .RD_LATENCY(2), .ARB_MODE(0)
  ) u_dut_rr (
    .clk(clk), .reset(reset),
    .m_req(m_req[0]), .m_we(m_we[0]), .m_adr(m_adr[0]), .m_wdata(m_wdata[0]),
    .m_gnt(m_gnt[0]), .m_rvalid(m_rvalid[0]), .m_rdata(m_rdata[0]),
    .memdata(memdata[0]), .memwrite(memwrite[0]), .adr(adr[0]), .memOut(mem_out[0])
  );

  arroz_mem_arbiter #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_MASTERS(N), .RD_LATENCY(1), .ARB_MODE(1)
  ) u_dut_fp (
    .clk(clk), .reset(reset),
    .m_req(m_req[1]), .m_we(m_we[1]), .m_adr(m_adr[1]), .m_wdata(m_wdata[1]),
    .m_gnt(m_gnt[1]), .m_rvalid(m_rvalid[1]), .m_rdata(m_rdata[1]),
    .memdata(memdata[1]), .memwrite(memwrite[1]), .adr(adr[1]), .memOut(mem_out[1])
  );

  // Initial memory content, reloaded whenever reset is low.
  function automatic logic [W-1:0] pat(input int k, input int a);
    if (a == 'h40) return 16'hBEEF;
    return W'(a * 37 + k * 1000 + 5);
  endfunction

  // Memories: instance 0 registers the address once more (latency 2),
  // instance 1 reads straight off adr (latency 1).
  logic [W-1:0] mem [NI][256];
  logic [7:0]   adr_d0;

  always @(posedge clk) begin
    adr_d0 <= adr[0][7:0];
    for (int k = 0; k < NI; k++) begin
      if (!reset) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= pat(k, a);
      end else if (memwrite[k]) begin
        mem[k][adr[k][7:0]] <= mem_out[k];
      end
    end
  end

  assign memdata[0] = mem[0][adr_d0];
  assign memdata[1] = mem[1][adr[1][7:0]];

  // Reference model state
  int            ptr_m [NI];
  logic          e_we  [NI];
  logic [AW-1:0] e_adr [NI];
  logic [W-1:0]  e_out [NI];
  logic [N-1:0]  s_rv  [NI][8];
  logic [W-1:0]  s_rd  [NI][8];
  logic [W-1:0]  mm    [NI][256];
  int            acc   [NI];
  int            cyc;

  logic [N-1:0]  obs_gnt [NI];
  logic [N-1:0]  obs_rv  [NI];
  logic          obs_mw  [NI];
  logic [AW-1:0] obs_adr [NI];
  logic [W-1:0]  obs_rd  [NI];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit is_fixed(input int k);
    return k == 1;
  endfunction

  // Winner under the arbitration rules, -1 when nobody requests.
  function automatic int pick(input int k, input logic [N-1:0] r);
    if (is_fixed(k)) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int j = 0; j < N; j++) if (r[(ptr_m[k] + j) % N]) return (ptr_m[k] + j) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      ptr_m[k] = 0;
      e_we[k]  = 1'b0;
      e_adr[k] = '0;
      e_out[k] = '0;
      acc[k]   = -1;
      for (int s = 0; s < 8; s++) begin
        s_rv[k][s] = '0;
        s_rd[k][s] = '0;
      end
      for (int a = 0; a < 256; a++) mm[k][a] = pat(k, a);
    end
  endtask

  // One clock: check outputs at the falling edge, then commit accepts.
  task automatic step();
    int w [NI];
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      logic [N-1:0] eg;
      int slot;
      slot = cyc % 8;
      w[k] = pick(k, m_req[k]);
      eg = '0;
      if (w[k] >= 0) eg[w[k]] = 1'b1;
      obs_gnt[k] = m_gnt[k];
      obs_rv[k]  = m_rvalid[k];
      obs_mw[k]  = memwrite[k];
      obs_adr[k] = adr[k];
      obs_rd[k]  = m_rdata[k];
      chk($sformatf("i%0d_gnt", k), 64'(m_gnt[k]), 64'(eg));
      chk($sformatf("i%0d_memwrite", k), 64'(memwrite[k]), 64'(e_we[k]));
      chk($sformatf("i%0d_adr", k), 64'(adr[k]), 64'(e_adr[k]));
      chk($sformatf("i%0d_memOut", k), 64'(mem_out[k]), 64'(e_out[k]));
      chk($sformatf("i%0d_rvalid", k), 64'(m_rvalid[k]), 64'(s_rv[k][slot]));
      if (s_rv[k][slot] != '0)
        chk($sformatf("i%0d_rdata", k), 64'(m_rdata[k]), 64'(s_rd[k][slot]));
      s_rv[k][slot] = '0;
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      acc[k] = -1;
      if (reset === 1'b1) begin
        e_we[k] = 1'b0;
        if (w[k] >= 0) begin
          int i;
          int due;
          logic [AW-1:0] a;
          logic [W-1:0]  d;
          logic [N-1:0]  own;
          i   = w[k];
          a   = m_adr[k][i*AW +: AW];
          d   = m_wdata[k][i*W +: W];
          own = '0;
          own[i] = 1'b1;
          acc[k] = i;
          if (!is_fixed(k)) ptr_m[k] = (i + 1) % N;
          e_adr[k] = a;
          e_out[k] = d;
          e_we[k]  = m_we[k][i];
          if (m_we[k][i]) begin
            mm[k][a[7:0]] = d;
          end else begin
            due = (cyc + lat(k) + 1) % 8;
            s_rv[k][due] = own;
            s_rd[k][due] = mm[k][a[7:0]];
          end
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_req(input int k, input int i, input logic we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    m_req[k][i] = 1'b1;
    m_we[k][i]  = we;
    m_adr[k][i*AW +: AW] = a;
    m_wdata[k][i*W +: W] = d;
  endtask

  task automatic rand_req(input int k, input int i);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    set_req(k, i, ($urandom_range(0, 2) == 0), a, W'($urandom));
  endtask

  task automatic clr_all();
    for (int k = 0; k < NI; k++) m_req[k] = '0;
  endtask

  task automatic drop_acc();
    for (int k = 0; k < NI; k++) if (acc[k] >= 0) m_req[k][acc[k]] = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      m_req[k] = '0; m_we[k] = '0; m_adr[k] = '0; m_wdata[k] = '0;
    end
    cyc = 0;
    model_reset();
    step();
    step();
    reset = 1'b1;
    step();

    // Reset while a latency-2 read by m1 is in flight
    set_req(0, 1, 1'b0, 16'h0022, 16'h0);
    step();
    drop_acc();
    step();
    reset = 1'b0;
    model_reset();
    step();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t1_no_rvalid", 64'(obs_rv[0]), 64'(0));
    end

    // Round-robin fairness with all three requesting
    for (int i = 0; i < N; i++) set_req(0, i, 1'b0, AW'(16'h0100 + i), 16'h0);
    for (int n = 0; n < 6; n++) begin
      logic [N-1:0] eg;
      eg = '0;
      eg[n % 3] = 1'b1;
      step();
      chk("t2_rr_gnt", 64'(obs_gnt[0]), 64'(eg));
      if (n > 0) chk("t2_adr", 64'(obs_adr[0]), 64'(16'h0100 + (n - 1) % 3));
    end
    clr_all();
    repeat (4) step();

    // Fixed priority: m1 alone-ish, then m0 starves m2
    set_req(1, 1, 1'b0, 16'h0031, 16'h0);
    set_req(1, 2, 1'b0, 16'h0032, 16'h0);
    step();
    chk("t3_gnt_m1", 64'(obs_gnt[1]), 64'(3'b010));
    set_req(1, 0, 1'b0, 16'h0030, 16'h0);
    set_req(1, 1, 1'b0, 16'h0033, 16'h0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t3_gnt_m0", 64'(obs_gnt[1]), 64'(3'b001));
    end
    clr_all();
    repeat (3) step();

    // Latency-1 read by m2
    set_req(1, 2, 1'b0, 16'h0040, 16'h0);
    step();
    chk("t4_gnt_m2", 64'(obs_gnt[1]), 64'(3'b100));
    drop_acc();
    step();
    chk("t4_c1_rvalid", 64'(obs_rv[1]), 64'(0));
    step();
    chk("t4_c2_rvalid", 64'(obs_rv[1]), 64'(3'b100));
    chk("t4_c2_rdata", 64'(obs_rd[1]), 64'(16'hBEEF));
    step();
    chk("t4_c3_rvalid", 64'(obs_rv[1]), 64'(0));

    // Write then read of the same address from different masters
    set_req(0, 0, 1'b1, 16'h0010, 16'h1234);
    step();
    drop_acc();
    set_req(0, 1, 1'b0, 16'h0010, 16'h0);
    step();
    chk("t5_memwrite_c1", 64'(obs_mw[0]), 64'(1));
    drop_acc();
    step();
    chk("t5_memwrite_c2", 64'(obs_mw[0]), 64'(0));
    chk("t5_c2_rvalid", 64'(obs_rv[0]), 64'(0));
    step();
    chk("t5_c3_rvalid", 64'(obs_rv[0]), 64'(0));
    step();
    chk("t5_c4_rvalid", 64'(obs_rv[0]), 64'(3'b010));
    chk("t5_c4_rdata", 64'(obs_rd[0]), 64'(16'h1234));

    // Pointer wrap from 2 to m0, then idle
    set_req(0, 0, 1'b0, 16'h0055, 16'h0);
    step();
    chk("t6_gnt_m0", 64'(obs_gnt[0]), 64'(3'b001));
    drop_acc();
    step();
    chk("t6_idle_gnt", 64'(obs_gnt[0]), 64'(0));
    chk("t6_adr", 64'(obs_adr[0]), 64'(16'h0055));
    step();
    chk("t6_idle_memwrite", 64'(obs_mw[0]), 64'(0));
    chk("t6_idle_adr", 64'(obs_adr[0]), 64'(16'h0055));
    for (int i = 0; i < N; i++) set_req(0, i, 1'b0, AW'(16'h0060 + i), 16'h0);
    step();
    chk("t6_ptr_next_m1", 64'(obs_gnt[0]), 64'(3'b010));
    clr_all();
    repeat (4) step();

    // Random traffic on both instances, with one reset midway
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < N; i++) begin
          if (acc[k] == i) begin
            if ($urandom_range(0, 2) == 0) rand_req(k, i);
            else m_req[k][i] = 1'b0;
          end else if (!m_req[k][i] && ($urandom_range(0, 1) == 1)) begin
            rand_req(k, i);
          end
        end
      end
      if (n == 300) begin
        reset = 1'b0;
        model_reset();
        clr_all();
        step();
        reset = 1'b1;
      end
      step();
    end
    clr_all();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
